// File: rtl/mem_stage.sv
// MIPS MEM stage: little-endian byte-addressed data memory with sized loads/stores,
// WB pass-through and a valid/ready memory-dump FSM. Optional store counter: MEM_STORE_COUNT_EN.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module mem_stage #(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDR     = 7,
   parameter int NB_REG      = 5,
   parameter int NB_WB_CTRL  = 3,
   parameter int NB_MEM_CTRL = 5
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     enable_pipe_i,
   input  logic [NB_DATA-1:0]       alu_result_i,
   input  logic [NB_DATA-1:0]       write_data_i,
   input  logic [NB_MEM_CTRL-1:0]   MEM_control_i,
   input  logic [NB_WB_CTRL-1:0]    WB_control_i,
   input  logic [NB_REG-1:0]        write_register_i,
   input  logic [`ADDRWIDTH-1:0]    pc_i,
   input  logic [NB_DATA-1:0]       data_inm_i,
   input  logic                     halt_detected_i,
   output logic [NB_DATA-1:0]       mem_data_o,
   output logic [NB_DATA-1:0]       alu_result_o,
   output logic [NB_WB_CTRL-1:0]    WB_control_o,
   output logic [NB_REG-1:0]        write_register_o,
   output logic [`ADDRWIDTH-1:0]    pc_o,
   output logic [NB_DATA-1:0]       inm_ext_o,
   output logic                     halt_detected_o,
   output logic                     misaligned_o,
   input  logic                     dump_start_i,
   input  logic                     dump_ready_i,
   output logic                     dump_valid_o,
   output logic [NB_DATA-1:0]       dump_data_o,
   output logic [NB_ADDR-1:0]       dump_addr_o,
   output logic                     dump_busy_o,
   output logic                     dump_done_o,
   output logic [31:0]              store_count_o
);

   localparam int DEPTH    = 2**NB_ADDR;
   localparam int NB_LANES = NB_DATA / 8;

   typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

   logic [NB_DATA-1:0]  mem_q [DEPTH];
   logic                mem_write;
   logic                mem_read;
   logic                is_unsigned;
   logic [1:0]          size;
   logic [NB_ADDR-1:0]  word_idx;
   logic [1:0]          lane;
   logic                aligned;
   logic                store_go;
   logic [NB_LANES-1:0] byte_en;
   logic [NB_DATA-1:0]  wr_data;
   logic [NB_DATA-1:0]  rd_word;
   logic [7:0]          sel_byte;
   logic [15:0]         sel_half;
   logic                misaligned_q;
   dump_state_t         state_q, state_d;
   logic [NB_ADDR-1:0]  dump_addr_q, dump_addr_d;

   assign mem_write   = MEM_control_i[4];
   assign mem_read    = MEM_control_i[3];
   assign is_unsigned = MEM_control_i[2];
   assign size        = MEM_control_i[1:0];
   assign word_idx    = alu_result_i[NB_ADDR+1:2];
   assign lane        = alu_result_i[1:0];

   // Size 2'b10 is reserved and treated as a word access.
   always_comb begin
      aligned = 1'b0;
      case (size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~lane[0];
         default: aligned = (lane == 2'b00);
      endcase
   end

   assign store_go = enable_pipe_i & mem_write & aligned & ~dump_busy_o;

   generate
      for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
         localparam logic [1:0] LANE_ID = 2'(gi);
         assign byte_en[gi] = (size == 2'b00) ? (lane == LANE_ID) :
                              (size == 2'b01) ? (lane[1] == LANE_ID[1]) : 1'b1;
         assign wr_data[8*gi +: 8] = (size == 2'b00) ? write_data_i[7:0] :
                                     (size == 2'b01) ? write_data_i[8*(gi%2) +: 8] :
                                                       write_data_i[8*gi +: 8];
      end
   endgenerate

   // Array is deliberately left out of reset so it maps onto RAM primitives.
   always_ff @(posedge clock_i) begin
      if (store_go) begin
         for (int i = 0; i < NB_LANES; i++) begin
            if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_word  = mem_q[word_idx];
   assign sel_byte = rd_word[{lane, 3'b000} +: 8];
   assign sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      mem_data_o = '0;
      if (mem_read && aligned) begin
         case (size)
            2'b00:   mem_data_o = is_unsigned ? {{(NB_DATA-8){1'b0}}, sel_byte}
                                              : {{(NB_DATA-8){sel_byte[7]}}, sel_byte};
            2'b01:   mem_data_o = is_unsigned ? {{(NB_DATA-16){1'b0}}, sel_half}
                                              : {{(NB_DATA-16){sel_half[15]}}, sel_half};
            default: mem_data_o = rd_word;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         misaligned_q <= 1'b0;
      end else if (enable_pipe_i && (mem_write || mem_read) && !aligned) begin
         misaligned_q <= 1'b1;
      end
   end
   assign misaligned_o = misaligned_q;

   assign alu_result_o     = alu_result_i;
   assign WB_control_o     = WB_control_i;
   assign write_register_o = write_register_i;
   assign pc_o             = pc_i;
   assign inm_ext_o        = data_inm_i;
   assign halt_detected_o  = halt_detected_i;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         dump_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         dump_addr_q <= dump_addr_d;
      end
   end

   // Stores are blocked while busy, so dump_data_o stays stable until each handshake.
   always_comb begin
      state_d      = state_q;
      dump_addr_d  = dump_addr_q;
      dump_valid_o = 1'b0;
      dump_busy_o  = 1'b0;
      dump_done_o  = 1'b0;
      dump_data_o  = '0;
      case (state_q)
         IDLE: begin
            if (dump_start_i && !enable_pipe_i) begin
               state_d     = SEND;
               dump_addr_d = '0;
            end
         end
         SEND: begin
            dump_valid_o = 1'b1;
            dump_busy_o  = 1'b1;
            dump_data_o  = mem_q[dump_addr_q];
            if (dump_ready_i) begin
               if (dump_addr_q == {NB_ADDR{1'b1}}) state_d = DONE;
               else                                dump_addr_d = dump_addr_q + 1'b1;
            end
         end
         DONE: begin
            dump_busy_o = 1'b1;
            dump_done_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign dump_addr_o = dump_addr_q;

`ifdef MEM_STORE_COUNT_EN
   logic [31:0] store_count_q;
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)       store_count_q <= '0;
      else if (store_go) store_count_q <= store_count_q + 32'd1;
   end
   assign store_count_o = store_count_q;
`else
   assign store_count_o = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: loads, stores, misalignment, dump handshake, async reset.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module tb_mem_stage;
   localparam int DEPTH = 128;
`ifdef MEM_STORE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   en;
   logic [31:0]            alu, wdata, inm;
   logic [4:0]             mctrl;
   logic [2:0]             wbctrl;
   logic [4:0]             wreg;
   logic [`ADDRWIDTH-1:0]  pc;
   logic                   halt;
   logic                   dump_start, dump_ready;
   logic [31:0]            mem_data_o, alu_result_o, inm_ext_o, dump_data_o, store_count_o;
   logic [2:0]             wb_o;
   logic [4:0]             wreg_o;
   logic [`ADDRWIDTH-1:0]  pc_o;
   logic                   halt_o, misaligned_o, dump_valid_o, dump_busy_o, dump_done_o;
   logic [6:0]             dump_addr_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   logic [31:0] model_mem [DEPTH];
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clock_i(clk), .reset_i(rst), .enable_pipe_i(en),
      .alu_result_i(alu), .write_data_i(wdata), .MEM_control_i(mctrl),
      .WB_control_i(wbctrl), .write_register_i(wreg), .pc_i(pc),
      .data_inm_i(inm), .halt_detected_i(halt),
      .mem_data_o(mem_data_o), .alu_result_o(alu_result_o), .WB_control_o(wb_o),
      .write_register_o(wreg_o), .pc_o(pc_o), .inm_ext_o(inm_ext_o),
      .halt_detected_o(halt_o), .misaligned_o(misaligned_o),
      .dump_start_i(dump_start), .dump_ready_i(dump_ready),
      .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o), .dump_addr_o(dump_addr_o),
      .dump_busy_o(dump_busy_o), .dump_done_o(dump_done_o), .store_count_o(store_count_o)
   );

   // Drives one store for a cycle; the model is updated only when the store should land.
   task automatic drive_store(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] sz, input bit performed);
      logic [1:0] ln;
      ln = addr[1:0];
      en = 1'b1; alu = addr; wdata = data; mctrl = {1'b1, 1'b0, 1'b0, sz};
      @(posedge clk); #1;
      mctrl = '0;
      if (performed) begin
         exp_cnt++;
         for (int j = 0; j < 4; j++) begin
            if (sz == 2'b00 && j == int'(ln))
               model_mem[addr[8:2]][8*j +: 8] = data[7:0];
            else if (sz == 2'b01 && (j / 2) == int'(ln[1]))
               model_mem[addr[8:2]][8*j +: 8] = data[8*(j%2) +: 8];
            else if (sz[1])
               model_mem[addr[8:2]][8*j +: 8] = data[8*j +: 8];
         end
      end
   endtask

   task automatic drive_load(input logic [31:0] addr, input logic rd,
                             input logic uns, input logic [1:0] sz);
      en = 1'b1; alu = addr; mctrl = {1'b0, rd, uns, sz};
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; #3;
      for (int k = 0; k < 7; k++) exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, dump_valid_o} !== exp_v) begin n_fail++; $display("FAIL reset_valid got %h exp %h", dump_valid_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, dump_busy_o} !== exp_v) begin n_fail++; $display("FAIL reset_busy got %h exp %h", dump_busy_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, dump_done_o} !== exp_v) begin n_fail++; $display("FAIL reset_done got %h exp %h", dump_done_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if ({25'd0, dump_addr_o} !== exp_v) begin n_fail++; $display("FAIL reset_addr got %h exp %h", dump_addr_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if (dump_data_o !== exp_v) begin n_fail++; $display("FAIL reset_data got %h exp %h", dump_data_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, misaligned_o} !== exp_v) begin n_fail++; $display("FAIL reset_misaligned got %h exp %h", misaligned_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if (store_count_o !== exp_v) begin n_fail++; $display("FAIL reset_count got %h exp %h", store_count_o, exp_v); end
      @(posedge clk); #1; rst = 1'b0;
      alu = 32'h1234_5678; wbctrl = 3'b101; wreg = 5'd17; pc = 'h0000_ABCD;
      inm = 32'hFFFF_8001; halt = 1'b1; #1;
      exp_q.push_back(32'h1234_5678);
      exp_q.push_back({wbctrl, wreg, 23'd0, halt});
      exp_q.push_back(32'hFFFF_8001);
      exp_v = exp_q.pop_front(); n_checks++;
      if (alu_result_o !== exp_v) begin n_fail++; $display("FAIL pass_alu got %h exp %h", alu_result_o, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if ({wb_o, wreg_o, 23'd0, halt_o} !== exp_v) begin n_fail++; $display("FAIL pass_ctrl got %h exp %h", {wb_o, wreg_o, 23'd0, halt_o}, exp_v); end
      exp_v = exp_q.pop_front(); n_checks++;
      if (inm_ext_o !== exp_v || pc_o !== pc) begin n_fail++; $display("FAIL pass_inm_pc got %h/%h exp %h/%h", inm_ext_o, pc_o, exp_v, pc); end
      halt = 1'b0; $display("reset and pass-through checked");
   endtask

   task automatic test_word_store;
      logic [31:0] addrs [5] = '{32'h08, 32'h0B, 32'h0B, 32'h08, 32'h08};
      logic [4:0]  ctl   [5] = '{5'b01011, 5'b01000, 5'b01100, 5'b01001, 5'b00011};
      logic [31:0] expd  [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0};
      drive_store(32'h08, 32'hDEADBEEF, 2'b11, 1'b1);
      $display("store word 0x08 = deadbeef");
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(expd[k]);
         drive_load(addrs[k], ctl[k][3], ctl[k][2], ctl[k][1:0]);
         exp_v = exp_q.pop_front(); n_checks++;
         if (mem_data_o !== exp_v) begin n_fail++; $display("FAIL word_load%0d got %h exp %h", k, mem_data_o, exp_v); end
         else $display("load addr=%h ctrl=%b data=%h", addrs[k], ctl[k], mem_data_o);
         mctrl = '0;
      end
   endtask

   task automatic test_byte_store;
      logic [31:0] addrs [4] = '{32'h10, 32'h12, 32'h10, 32'h11};
      logic [4:0]  ctl   [4] = '{5'b01011, 5'b01001, 5'b01101, 5'b01000};
      logic [31:0] expd  [4] = '{32'h00007F00, 32'h0, 32'h00007F00, 32'h0000007F};
      drive_store(32'h10, 32'h0, 2'b11, 1'b1);
      drive_store(32'h11, 32'hAAAA_AA7F, 2'b00, 1'b1);
      $display("store byte 0x11 = 7f");
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(expd[k]);
         drive_load(addrs[k], ctl[k][3], ctl[k][2], ctl[k][1:0]);
         exp_v = exp_q.pop_front(); n_checks++;
         if (mem_data_o !== exp_v) begin n_fail++; $display("FAIL byte_load%0d got %h exp %h", k, mem_data_o, exp_v); end
         else $display("load addr=%h ctrl=%b data=%h", addrs[k], ctl[k], mem_data_o);
         mctrl = '0;
      end
   endtask

   task automatic test_misaligned;
      drive_store(32'h04, 32'hA5A5_A5A5, 2'b11, 1'b1);
      exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, misaligned_o} !== exp_v) begin n_fail++; $display("FAIL misaligned_pre got %h exp %h", misaligned_o, exp_v); end
      drive_store(32'h05, 32'h0000_1234, 2'b01, 1'b0);
      $display("misaligned store half 0x05 = 1234");
      exp_q.push_back(32'd1);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, misaligned_o} !== exp_v) begin n_fail++; $display("FAIL misaligned_set got %h exp %h", misaligned_o, exp_v); end
      exp_q.push_back(model_mem[1]);
      drive_load(32'h04, 1'b1, 1'b0, 2'b11);
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_data_o !== exp_v) begin n_fail++; $display("FAIL misaligned_mem got %h exp %h", mem_data_o, exp_v); end
      mctrl = '0;
      exp_q.push_back(CNT_EN ? exp_cnt : 32'd0);
      exp_v = exp_q.pop_front(); n_checks++;
      if (store_count_o !== exp_v) begin n_fail++; $display("FAIL store_count got %h exp %h", store_count_o, exp_v); end
      exp_q.push_back(32'd0);
      drive_load(32'h09, 1'b1, 1'b0, 2'b11);
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_data_o !== exp_v) begin n_fail++; $display("FAIL misaligned_load got %h exp %h", mem_data_o, exp_v); end
      mctrl = '0;
      repeat (3) @(posedge clk); #1;
      exp_q.push_back(32'd1);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, misaligned_o} !== exp_v) begin n_fail++; $display("FAIL misaligned_sticky got %h exp %h", misaligned_o, exp_v); end
   endtask

   task automatic test_dump;
      for (int i = 0; i < DEPTH; i++) drive_store(i * 4, i + 1, 2'b11, 1'b1);
      en = 1'b0; dump_ready = 1'b0; dump_start = 1'b1;
      @(posedge clk); #1; dump_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(32'd1);
         exp_v = exp_q.pop_front(); n_checks++;
         if (dump_data_o !== exp_v || dump_valid_o !== 1'b1 || dump_addr_o !== 7'd0) begin
            n_fail++; $display("FAIL dump_stall%0d got %h v=%b a=%0d exp %h", k, dump_data_o, dump_valid_o, dump_addr_o, exp_v);
         end
         @(posedge clk); #1;
      end
      dump_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_mem[i]);
      for (int i = 0; i < DEPTH; i++) begin
         exp_v = exp_q.pop_front(); n_checks++;
         if (dump_data_o !== exp_v || dump_addr_o !== 7'(i) || dump_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL dump_word%0d got %h a=%0d v=%b exp %h", i, dump_data_o, dump_addr_o, dump_valid_o, exp_v);
         end
         @(posedge clk); #1;
      end
      dump_ready = 1'b0;
      exp_q.push_back(32'b110);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({29'd0, dump_done_o, dump_busy_o, dump_valid_o} !== exp_v) begin
         n_fail++; $display("FAIL dump_done got d/b/v=%b%b%b exp %b", dump_done_o, dump_busy_o, dump_valid_o, exp_v[2:0]);
      end
      @(posedge clk); #1;
      exp_q.push_back(32'b000);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({29'd0, dump_done_o, dump_busy_o, dump_valid_o} !== exp_v) begin
         n_fail++; $display("FAIL dump_idle got d/b/v=%b%b%b exp %b", dump_done_o, dump_busy_o, dump_valid_o, exp_v[2:0]);
      end
      $display("dump of %0d words complete", DEPTH);
   endtask

   task automatic test_dump_ignored;
      bit seen_done;
      en = 1'b1; dump_start = 1'b1;
      @(posedge clk); #1; dump_start = 1'b0;
      exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, dump_busy_o} !== exp_v) begin n_fail++; $display("FAIL start_while_enabled got %h exp %h", dump_busy_o, exp_v); end
      en = 1'b0; dump_ready = 1'b0; dump_start = 1'b1;
      @(posedge clk); #1; dump_start = 1'b0;
      drive_store(32'h0C, 32'hCAFE_F00D, 2'b11, 1'b0);
      $display("store during dump 0x0c = cafef00d (dropped)");
      exp_q.push_back(32'd1);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({31'd0, dump_busy_o} !== exp_v) begin n_fail++; $display("FAIL dump_not_aborted got %h exp %h", dump_busy_o, exp_v); end
      dump_ready = 1'b1; seen_done = 1'b0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
         @(posedge clk); #1;
         if (dump_done_o) seen_done = 1'b1;
      end
      dump_ready = 1'b0;
      n_checks++;
      if (!seen_done) begin n_fail++; $display("FAIL dump_timeout got no done pulse exp done within 300 cycles"); end
      @(posedge clk); #1;
      exp_q.push_back(model_mem[3]);
      drive_load(32'h0C, 1'b1, 1'b0, 2'b11);
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_data_o !== exp_v) begin n_fail++; $display("FAIL dropped_store got %h exp %h", mem_data_o, exp_v); end
      mctrl = '0;
   endtask

   task automatic test_async_reset;
      en = 1'b0; dump_ready = 1'b0; dump_start = 1'b1;
      @(posedge clk); #1; dump_start = 1'b0; dump_ready = 1'b1;
      repeat (5) @(posedge clk); #1;
      dump_ready = 1'b0;
      exp_q.push_back(32'd5);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({25'd0, dump_addr_o} !== exp_v) begin n_fail++; $display("FAIL pre_reset_addr got %h exp %h", dump_addr_o, exp_v); end
      #2 rst = 1'b1; exp_cnt = 0;
      #1;
      exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); n_checks++;
      if ({dump_valid_o, dump_busy_o, dump_done_o, misaligned_o, 21'd0, dump_addr_o} !== exp_v) begin
         n_fail++; $display("FAIL async_reset_ctrl got v=%b b=%b d=%b m=%b a=%0d exp all 0", dump_valid_o, dump_busy_o, dump_done_o, misaligned_o, dump_addr_o);
      end
      exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); n_checks++;
      if ((dump_data_o | store_count_o) !== exp_v) begin n_fail++; $display("FAIL async_reset_data got %h/%h exp %h", dump_data_o, store_count_o, exp_v); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(model_mem[2]);
      drive_load(32'h08, 1'b1, 1'b0, 2'b11);
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_data_o !== exp_v) begin n_fail++; $display("FAIL mem_after_reset got %h exp %h", mem_data_o, exp_v); end
      mctrl = '0;
      $display("async reset mid-dump checked");
   endtask

   initial begin
      en = 1'b0; alu = '0; wdata = '0; mctrl = '0; wbctrl = '0; wreg = '0; pc = '0;
      inm = '0; halt = 1'b0; dump_start = 1'b0; dump_ready = 1'b0; rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      test_reset();
      test_word_store();
      test_byte_store();
      test_misaligned();
      test_dump();
      test_dump_ignored();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
